// File: rtl/sipo_capture_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_capture_ctrl
//
// Sequencer for the serial-in/parallel-out capture path. A programmable
// divider paces bit sampling; one shift strobe is issued per bit. After a
// fixed-width frame has been shifted in, the assembled word is offered to
// downstream logic over a valid/ready handshake. If a new word completes while
// the previous one is still unconsumed, the new word is dropped and a sticky
// overrun flag is raised.
//
// Parameters:
//   DIV    clock cycles per bit tick (1..1024)
//   WIDTH  bits per frame (2..32)
//
// Ports:
//   i_CLK    system clock, rising edge
//   i_RST    synchronous, active-high reset
//   i_SDI    serial data, MSB first, sampled on bit ticks
//   i_START  request to capture one frame, honoured only in IDLE
//   o_BUSY   high whenever the sequencer is not IDLE
//   o_SFT    one-cycle shift strobe per bit (SIPO shift enable)
//   o_DATA   last completed word
//   o_VALID  o_DATA holds an unconsumed word
//   i_READY  consumer accepts o_DATA when o_VALID and i_READY are both high
//   o_OVR    sticky overrun, cleared only by reset
// -----------------------------------------------------------------------------
module sipo_capture_ctrl #(
    parameter int DIV   = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_SDI,
    input  logic             i_START,
    output logic             o_BUSY,
    output logic             o_SFT,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic             o_OVR
);

    // The divider keeps at least one bit so DIV=1 still elaborates cleanly;
    // in that case it simply stays at zero and every SHIFT cycle is a tick.
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCNT_W = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DIV_W-1:0]    div;
    logic [BCNT_W-1:0]   bcnt;
    logic [WIDTH-1:0]    sr;
    logic                sft;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_nxt unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_START) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // The tick that captures the last bit ends the frame.
                if (sft && (bcnt == BCNT_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Combinational outputs: decoded from state and divider only
    // -------------------------------------------------------------------------
    always_comb begin
        o_BUSY = (state != IDLE);
        sft    = (state == SHIFT) && (div == DIV_LAST);
    end

    assign o_SFT = sft;

    // -------------------------------------------------------------------------
    // Divider, bit counter and shift register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            div  <= '0;
            bcnt <= '0;
            // NOTE: the shift register is cleared on reset even though a full
            // frame overwrites it, so a reset mid-frame leaves no partial word.
            sr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_START) begin
                        div  <= '0;
                        bcnt <= '0;
                    end
                end
                SHIFT: begin
                    if (sft) begin
                        sr   <= {sr[WIDTH-2:0], i_SDI};
                        div  <= '0;
                        bcnt <= bcnt + BCNT_W'(1);
                    end else begin
                        div  <= div + DIV_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output buffer and handshake
    // -------------------------------------------------------------------------
    // In DONE, a consumer accepting on the same edge frees the buffer, so the
    // new word loads and o_VALID simply stays high.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_DATA  <= '0;
            o_VALID <= 1'b0;
            o_OVR   <= 1'b0;
        end else if (state == DONE) begin
            if (!o_VALID || i_READY) begin
                o_DATA  <= sr;
                o_VALID <= 1'b1;
            end else begin
                o_OVR   <= 1'b1;
            end
        end else if (o_VALID && i_READY) begin
            o_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_capture_ctrl
//
// Self-checking bench for sipo_capture_ctrl. A DIV=4/WIDTH=8 instance is
// checked every cycle against an event-time reference model (bit n of a frame
// started at edge k is sampled at edge k+n*DIV, the word is delivered at edge
// k+WIDTH*DIV+1). Directed sequences, a table of frames and random traffic
// drive it. A second DIV=1 instance covers the back-to-back strobe case.
// -----------------------------------------------------------------------------
module tb_sipo_capture_ctrl;

    localparam int D     = 4;
    localparam int W     = 8;
    localparam int FRAME = W * D + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DIV=4 instance
    logic         rst, start, sdi, ready;
    logic         busy, sft, valid, ovr;
    logic [W-1:0] data;

    sipo_capture_ctrl #(.DIV(D), .WIDTH(W)) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_SDI   (sdi),
        .i_START (start),
        .o_BUSY  (busy),
        .o_SFT   (sft),
        .o_DATA  (data),
        .o_VALID (valid),
        .i_READY (ready),
        .o_OVR   (ovr)
    );

    // DIV=1 instance
    logic         rst1 = 1'b1, start1 = 1'b0, sdi1 = 1'b0, ready1 = 1'b0;
    logic         busy1, sft1, valid1, ovr1;
    logic [W-1:0] data1;

    sipo_capture_ctrl #(.DIV(1), .WIDTH(W)) dut1 (
        .i_CLK   (clk),
        .i_RST   (rst1),
        .i_SDI   (sdi1),
        .i_START (start1),
        .o_BUSY  (busy1),
        .o_SFT   (sft1),
        .o_DATA  (data1),
        .o_VALID (valid1),
        .i_READY (ready1),
        .o_OVR   (ovr1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model (frame timing expressed as edge arithmetic)
    // -------------------------------------------------------------------------
    int           ecnt = 0;      // index of the upcoming rising edge
    bit           m_busy = 1'b0;
    int           m_k = 0;       // edge at which the current frame started
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_data = '0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;
    int           sft_seen = 0;

    function automatic bit exp_sft();
        int rel;
        rel = ecnt - m_k;
        return m_busy && (rel >= 1) && (rel <= W * D) && (rel % D == 0);
    endfunction

    task automatic model_edge();
        int rel;
        bit busy_pre;
        rel      = ecnt - m_k;
        busy_pre = m_busy;
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_ovr   = 1'b0;
        end else begin
            if (busy_pre && rel >= 1 && rel <= W * D && rel % D == 0)
                m_word = {m_word[W-2:0], sdi};
            if (busy_pre && rel == FRAME) begin
                if (!m_valid || ready) begin
                    m_data  = m_word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                m_busy = 1'b0;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            if (!busy_pre && start) begin
                m_busy = 1'b1;
                m_k    = ecnt;
            end
        end
        ecnt++;
    endtask

    // Called at a falling edge: compare, advance one rising edge, return at
    // the next falling edge.
    task automatic cycle(input bit chk);
        if (chk) begin
            check("busy",  32'(busy),  32'(m_busy));
            check("sft",   32'(sft),   32'(exp_sft()));
            check("valid", 32'(valid), 32'(m_valid));
            check("data",  32'(data),  32'(m_data));
            check("ovr",   32'(ovr),   32'(m_ovr));
        end
        if (sft === 1'b1) sft_seen++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit chk);
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        sdi   = 1'b0;
        cycle(chk);
        rst   = 1'b0;
    endtask

    // One frame from IDLE; ready is held at rdy_during except on the DONE edge.
    task automatic run_frame(input logic [W-1:0] word, input bit rdy_during, input bit rdy_done);
        int n;
        start = 1'b1;
        ready = rdy_during;
        sdi   = 1'b0;
        cycle(1'b1);
        start = 1'b0;
        for (int t = 1; t <= FRAME; t++) begin
            n = (t + D - 1) / D;
            if (n <= W) sdi = word[W-n];
            else        sdi = 1'b0;
            ready = (t == FRAME) ? rdy_done : rdy_during;
            cycle(1'b1);
        end
        ready = 1'b0;
    endtask

    typedef struct {
        bit           rst_before;
        logic [W-1:0] word;
        bit           rdy_frame;
        bit           rdy_done;
        logic [W-1:0] exp_data;
        bit           exp_valid;
        bit           exp_ovr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h96, 1'b0, 1'b1, 8'h96, 1'b1, 1'b0}; // accept+load at DONE
        vecs[2] = '{1'b0, 8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'hF0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'hC3, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1}; // backpressure drop
        vecs[6] = '{1'b0, 8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1}; // sticky, still loads

        rst = 1'b1; start = 1'b0; ready = 1'b0; sdi = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        // Reset state
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_sft",   32'(sft),   32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data",  32'(data),  32'd0);
        check("rst_ovr",   32'(ovr),   32'd0);

        // Basic frame 0xA5 and handshake
        sft_seen = 0;
        run_frame(8'hA5, 1'b0, 1'b0);
        check("a5_sft_count", 32'(sft_seen), 32'd8);
        check("a5_valid",     32'(valid),    32'd1);
        check("a5_data",      32'(data),     32'hA5);
        check("a5_ovr",       32'(ovr),      32'd0);
        ready = 1'b1;
        cycle(1'b1);
        ready = 1'b0;
        check("a5_accept_valid", 32'(valid), 32'd0);
        check("a5_accept_data",  32'(data),  32'hA5);

        // Table of frames
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rst_before) do_reset(1'b1);
            run_frame(vecs[i].word, vecs[i].rdy_frame, vecs[i].rdy_done);
            check($sformatf("vec%0d_data", i),  32'(data),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ovr", i),   32'(ovr),   32'(vecs[i].exp_ovr));
        end

        // START held high across a whole frame
        do_reset(1'b1);
        start = 1'b1;
        ready = 1'b1;
        cycle(1'b1);
        sft_seen = 0;
        for (int t = 1; t <= FRAME; t++) begin
            sdi = 1'($urandom_range(0, 1));
            cycle(1'b1);
        end
        check("held_sft_count", 32'(sft_seen), 32'd8);
        check("held_idle_gap",  32'(busy),     32'd0);
        cycle(1'b1);
        check("held_restart",   32'(busy),     32'd1);
        start = 1'b0;
        for (int t = 0; t < FRAME + 4; t++) cycle(1'b1);
        ready = 1'b0;

        // Reset after the 5th bit of a frame
        do_reset(1'b1);
        run_frame(8'h5A, 1'b0, 1'b0);
        start = 1'b1;
        sdi   = 1'b0;
        cycle(1'b1);
        start = 1'b0;
        for (int t = 1; t <= 5 * D; t++) cycle(1'b1);
        rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0;
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_sft",   32'(sft),   32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_data",  32'(data),  32'd0);
        check("midrst_ovr",   32'(ovr),   32'd0);
        run_frame(8'hFF, 1'b0, 1'b0);
        check("midrst_ff_data",  32'(data),  32'hFF);
        check("midrst_ff_valid", 32'(valid), 32'd1);

        // Random traffic against the model
        do_reset(1'b1);
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 2) == 0);
            sdi   = 1'($urandom_range(0, 1));
            cycle(1'b1);
        end
        rst = 1'b0; start = 1'b0; ready = 1'b0;

        // DIV=1: strobes on consecutive cycles, word at edge k+9
        begin
            logic [W-1:0] w1;
            w1     = 8'h81;
            rst1   = 1'b0;
            start1 = 1'b1;
            check("div1_idle_busy", 32'(busy1), 32'd0);
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            for (int t = 1; t <= W + 1; t++) begin
                if (t <= W) sdi1 = w1[W-t];
                else        sdi1 = 1'b0;
                check($sformatf("div1_sft_t%0d", t),   32'(sft1),   32'(t <= W));
                check($sformatf("div1_busy_t%0d", t),  32'(busy1),  32'd1);
                check($sformatf("div1_valid_t%0d", t), 32'(valid1), 32'd0);
                @(posedge clk);
                @(negedge clk);
            end
            check("div1_valid", 32'(valid1), 32'd1);
            check("div1_data",  32'(data1),  32'h81);
            check("div1_ovr",   32'(ovr1),   32'd0);
            check("div1_busy",  32'(busy1),  32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
